// File: rtl/count_ud_mod_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// Mode select and load clamping live here so the bench and RTL agree.
package count_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    function automatic logic [31:0] clamp_to_mod(
        input logic [31:0] v,
        input logic [31:0] m
    );
        return (v < m) ? v : m - 32'd1;
    endfunction

endpackage

// File: rtl/count_ud_mod_if.sv
// Control/status bundle of the up/down modulo counter.
// The master drives controls, the counter (slave) drives status.
interface count_ud_mod_if #(
    parameter int WIDTH = 4
);
    import count_pkg::*;

    logic             iEN;
    logic             iUP;
    mode_e            iMODE;
    logic             iCLR;
    logic             iLOAD;
    logic [WIDTH-1:0] iLOAD_VAL;
    logic [WIDTH-1:0] oCOUNT;
    logic             oTC;
    logic             oWRAP;

    modport master (
        output iEN, iUP, iMODE, iCLR, iLOAD, iLOAD_VAL,
        input  oCOUNT, oTC, oWRAP
    );

    modport slave (
        input  iEN, iUP, iMODE, iCLR, iLOAD, iLOAD_VAL,
        output oCOUNT, oTC, oWRAP
    );

endinterface

// File: rtl/count_ud_mod_tick_gen.sv
// Clock-enable prescaler: one tick per DIV enabled clocks.
// Phase is held while iEN is low; DIV==1 keeps a constant 1-bit phase.
module tick_gen #(
    parameter int DIV = 1
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iEN,
    input  logic iCLR,
    output logic oTICK
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            presc <= '0;
        end else if (iCLR) begin
            presc <= '0;
        end else if (iEN) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    assign oTICK = iEN && (presc == LAST);

endmodule

// File: rtl/count_ud_mod.sv
// Parametrised up/down modulo counter with prescaler,
// synchronous clear/load and wrap or saturate behaviour.
module count_ud_mod
    import count_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int DIV     = 1
) (
    input logic           iCLK,
    input logic           iRST_N,
    count_ud_mod_if.slave bus
);
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
        $error("count_ud_mod: MODULUS out of range");
    end
    if (DIV < 1) begin : g_bad_div
        $error("count_ud_mod: DIV must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_q;
    logic             wrap_d;
    logic             tick;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (bus.iEN),
        .iCLR   (bus.iCLR | bus.iLOAD),
        .oTICK  (tick)
    );

    assign load_clamped = WIDTH'(clamp_to_mod(
        32'(bus.iLOAD_VAL), 32'(MODULUS)));

    // Wrap is explicit at MAX/0, never a natural 2**WIDTH roll.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.iCLR) begin
            cnt_d = '0;
        end else if (bus.iLOAD) begin
            cnt_d = load_clamped;
        end else if (tick) begin
            if (bus.iUP) begin
                if (cnt_q < MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (bus.iMODE == MODE_WRAP) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bus.iMODE == MODE_WRAP) begin
                    cnt_d  = MAX;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.oCOUNT = cnt_q;
    assign bus.oWRAP  = wrap_q;
    assign bus.oTC    = bus.iUP ? (cnt_q == MAX) : (cnt_q == '0);

endmodule

// File: tb/tb_count_ud_mod.sv
// Bench for count_ud_mod: three configurations share one stimulus
// and are compared each cycle against an arithmetic reference model.
module tb_count_ud_mod;
    import count_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    mode_e      mode = MODE_WRAP;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = '0;

    int checks = 0;
    int errors = 0;

    int modv [3] = '{16, 10, 16};
    int divv [3] = '{1, 1, 4};
    int mc [3];
    int mw [3];
    int mn [3];

    logic [3:0] oc [3];
    logic       ow [3];
    logic       ot [3];

    always #5 clk = ~clk;

    count_ud_mod_if #(.WIDTH(4)) ifa ();
    count_ud_mod_if #(.WIDTH(4)) ifb ();
    count_ud_mod_if #(.WIDTH(4)) ifc ();

    assign ifa.iEN = en;
    assign ifa.iUP = up;
    assign ifa.iMODE = mode;
    assign ifa.iCLR = clr;
    assign ifa.iLOAD = load;
    assign ifa.iLOAD_VAL = lv;
    assign ifb.iEN = en;
    assign ifb.iUP = up;
    assign ifb.iMODE = mode;
    assign ifb.iCLR = clr;
    assign ifb.iLOAD = load;
    assign ifb.iLOAD_VAL = lv;
    assign ifc.iEN = en;
    assign ifc.iUP = up;
    assign ifc.iMODE = mode;
    assign ifc.iCLR = clr;
    assign ifc.iLOAD = load;
    assign ifc.iLOAD_VAL = lv;

    assign oc[0] = ifa.oCOUNT;
    assign ow[0] = ifa.oWRAP;
    assign ot[0] = ifa.oTC;
    assign oc[1] = ifb.oCOUNT;
    assign ow[1] = ifb.oWRAP;
    assign ot[1] = ifb.oTC;
    assign oc[2] = ifc.oCOUNT;
    assign ow[2] = ifc.oWRAP;
    assign ot[2] = ifc.oTC;

    count_ud_mod #(.WIDTH(4), .MODULUS(16), .DIV(1)) u_a (
        .iCLK(clk), .iRST_N(rst_n), .bus(ifa));
    count_ud_mod #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_b (
        .iCLK(clk), .iRST_N(rst_n), .bus(ifb));
    count_ud_mod #(.WIDTH(4), .MODULUS(16), .DIV(4)) u_c (
        .iCLK(clk), .iRST_N(rst_n), .bus(ifc));

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mw[i] = 0;
            mn[i] = 0;
        end
    endtask

    // n counts enabled cycles since the last clear/load/reset.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit t;
            mw[i] = 0;
            if (clr) begin
                mc[i] = 0;
                mn[i] = 0;
            end else if (load) begin
                mc[i] = (int'(lv) < modv[i]) ? int'(lv) : modv[i] - 1;
                mn[i] = 0;
            end else begin
                t = en && ((mn[i] % divv[i]) == divv[i] - 1);
                if (en) mn[i]++;
                if (t && up) begin
                    if (mc[i] == modv[i] - 1) begin
                        if (mode == MODE_WRAP) begin
                            mc[i] = 0;
                            mw[i] = 1;
                        end
                    end else begin
                        mc[i] = mc[i] + 1;
                    end
                end else if (t) begin
                    if (mc[i] == 0) begin
                        if (mode == MODE_WRAP) begin
                            mc[i] = modv[i] - 1;
                            mw[i] = 1;
                        end
                    end else begin
                        mc[i] = mc[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            int tc;
            tc = up ? int'(mc[i] == modv[i] - 1) : int'(mc[i] == 0);
            check($sformatf("%s[%0d].count", tag, i), 32'(oc[i]), 32'(mc[i]));
            check($sformatf("%s[%0d].wrap", tag, i), 32'(ow[i]), 32'(mw[i]));
            check($sformatf("%s[%0d].tc", tag, i), 32'(ot[i]), 32'(tc));
        end
    endtask

    task automatic cyc(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #2;
            check_all(tag);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        en = 1'b1;
        up = 1'b1;
        mode = MODE_WRAP;
        cyc("up_wrap", 18);

        up = 1'b0;
        load = 1'b1;
        lv = 4'd2;
        cyc("dn_load", 1);
        load = 1'b0;
        cyc("dn_wrap", 5);

        up = 1'b1;
        mode = MODE_SAT;
        cyc("up_sat", 70);
        up = 1'b0;
        #1;
        check_all("tc_dn");
        up = 1'b1;
        #1;
        check_all("tc_up");

        en = 1'b0;
        mode = MODE_WRAP;
        load = 1'b1;
        lv = 4'd7;
        cyc("load7", 1);
        lv = 4'd13;
        cyc("load13", 1);
        clr = 1'b1;
        lv = 4'd5;
        cyc("clr_load", 1);
        clr = 1'b0;
        load = 1'b0;
        cyc("hold", 3);

        en = 1'b1;
        cyc("div_run", 10);
        en = 1'b0;
        cyc("div_gap", 3);
        en = 1'b1;
        cyc("div_resume", 10);

        clr = 1'b1;
        cyc("pre_rst", 1);
        clr = 1'b0;
        cyc("to5", 5);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 10);

        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(3) != 0);
            up = 1'($urandom_range(1));
            if ($urandom_range(15) == 0)
                mode = (mode == MODE_WRAP) ? MODE_SAT : MODE_WRAP;
            clr = ($urandom_range(31) == 0);
            load = ($urandom_range(19) == 0);
            lv = 4'($urandom_range(15));
            cyc("rand", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
